// File: rtl/mul_norm_rnd_pkg.sv
// Shared types and constants for the multiplier normalize/round pipeline.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mul_pkg;

    localparam int MUL_EXPO_W = 8;
    localparam int MUL_MANT_W = 23;
    localparam int PROD_W     = 2*MUL_MANT_W + 2;
    localparam int EXPO_MAX   = (1 << MUL_EXPO_W) - 1;

    typedef enum logic [1:0] {
        RTZ = 2'b00,
        RDN = 2'b01,
        RUP = 2'b10,
        RNE = 2'b11
    } rnd_mode_e;

    // Stage-1 register: normalized significand plus everything stage 2 needs.
    // e carries two extra bits so the +1 of normalization and of rounding
    // carry can never wrap the signed exponent.
    typedef struct packed {
        logic [MUL_MANT_W-1:0]         sig;
        logic                          g;
        logic                          s;
        logic signed [MUL_EXPO_W+2:0]  e;
        logic                          sign;
        logic                          is_zero;
        logic                          is_inf_nan;
        logic                          sign_nan;
        logic [MUL_MANT_W-1:0]         mant_nan;
        rnd_mode_e                     rnd;
    } s1_reg_t;

endpackage

// File: rtl/mul_norm_rnd_if.sv
// Beat interface between the product source, the normalize/round stage and the result mux.
// Latency: none (wires only).
// Backpressure: valid/ready on both the input and the output side.
interface mul_norm_rnd_if #(
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2*MANT_W+1:0]   prod;
    logic [EXPO_W+1:0]     expo_sum;
    logic                  sign_in;
    logic                  is_zero;
    logic                  is_inf_nan_in;
    logic                  sign_nan_in;
    logic [MANT_W-1:0]     mant_nan_in;
    logic [1:0]            rnd_in;

    logic                  out_valid;
    logic                  out_ready;
    logic                  is_inf_nan;
    logic                  sign_nan;
    logic [MANT_W-1:0]     mant_4;
    logic [1:0]            rnd;
    logic                  sign_1;
    logic                  overflow;
    logic [EXPO_W-1:0]     expo_3;
    logic [MANT_W-1:0]     mant_3;
    logic                  inexact;

    // Source/sink side (drives beats in, accepts results).
    modport master (
        output in_valid, prod, expo_sum, sign_in, is_zero, is_inf_nan_in,
               sign_nan_in, mant_nan_in, rnd_in, out_ready,
        input  in_ready, out_valid, is_inf_nan, sign_nan, mant_4, rnd, sign_1,
               overflow, expo_3, mant_3, inexact
    );

    // Normalize/round stage side.
    modport slave (
        input  in_valid, prod, expo_sum, sign_in, is_zero, is_inf_nan_in,
               sign_nan_in, mant_nan_in, rnd_in, out_ready,
        output in_ready, out_valid, is_inf_nan, sign_nan, mant_4, rnd, sign_1,
               overflow, expo_3, mant_3, inexact
    );

endinterface

// File: rtl/mul_norm_rnd_inc.sv
// Rounding-increment decision and mantissa increment for one normalized significand.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module mul_rnd_inc
    import mul_pkg::*;
#(
    parameter int MANT_W = 23
) (
    input  logic [MANT_W-1:0] sig,
    input  logic              g,
    input  logic              s,
    input  logic              sign,
    input  rnd_mode_e         rnd,
    output logic [MANT_W:0]   m,
    output logic              inc
);

    // Pick the increment for the selected mode, then add it one bit wider to expose carry-out.
    always_comb begin
        inc = 1'b0;
        case (rnd)
            RNE:     inc = g & (s | sig[0]);
            RUP:     inc = (g | s) & ~sign;
            RDN:     inc = (g | s) & sign;
            default: inc = 1'b0;
        endcase
        m = {1'b0, sig} + {{MANT_W{1'b0}}, inc};
    end

endmodule

// File: rtl/mul_norm_rnd.sv
// Two-stage normalize (stage 1) and round/flush/overflow (stage 2) of the FP multiplier product.
// Latency: 2 register stages from input accept to output register.
// Backpressure: per-stage valid/ready, full throughput; outputs hold while out_valid & !out_ready.
module mul_norm_rnd
    import mul_pkg::*;
#(
    parameter int EXPO_W = MUL_EXPO_W,
    parameter int MANT_W = MUL_MANT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    mul_norm_rnd_if.slave bus
);
    localparam int P  = 2*MANT_W + 1;
    localparam int EW = EXPO_W + 3;
    localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXPO_W) - 1);

    logic                  s1_valid_q, s1_valid_d;
    logic                  s2_valid_q, s2_valid_d;
    logic                  s2_ready, s1_load, s2_load;
    s1_reg_t               s1_q, s1_d;
    logic [EW-1:0]         e_ext;

    logic [MANT_W:0]       m;
    logic                  inc, carry;
    logic signed [EW-1:0]  e_r;
    logic [MANT_W-1:0]     mant_r;
    logic                  ovf_r, uflow_r;

    logic                  is_inf_nan_q, is_inf_nan_d;
    logic                  sign_nan_q, sign_nan_d;
    logic [MANT_W-1:0]     mant_4_q, mant_4_d;
    logic [1:0]            rnd_q, rnd_d;
    logic                  sign_1_q, sign_1_d;
    logic                  overflow_q, overflow_d;
    logic [EXPO_W-1:0]     expo_3_q, expo_3_d;
    logic [MANT_W-1:0]     mant_3_q, mant_3_d;
    logic                  inexact_q, inexact_d;

    assign s2_ready     = ~s2_valid_q | bus.out_ready;
    assign bus.in_ready = ~s1_valid_q | s2_ready;
    assign s1_load      = bus.in_valid & bus.in_ready;
    assign s2_load      = s1_valid_q & s2_ready;
    assign e_ext        = {bus.expo_sum[EXPO_W+1], bus.expo_sum};

    // Stage 1: align the product so the hidden bit drops out, split off guard and sticky.
    always_comb begin
        s1_d       = s1_q;
        s1_valid_d = s1_valid_q;
        if (bus.in_ready) begin
            s1_valid_d = bus.in_valid;
        end
        if (s1_load) begin
            if (bus.prod[P]) begin
                s1_d.sig = bus.prod[P-1:MANT_W+1];
                s1_d.g   = bus.prod[MANT_W];
                s1_d.s   = |bus.prod[MANT_W-1:0];
            end else begin
                s1_d.sig = bus.prod[P-2:MANT_W];
                s1_d.g   = bus.prod[MANT_W-1];
                s1_d.s   = |bus.prod[MANT_W-2:0];
            end
            s1_d.e          = e_ext + {{(EW-1){1'b0}}, bus.prod[P]};
            s1_d.sign       = bus.sign_in;
            s1_d.is_zero    = bus.is_zero;
            s1_d.is_inf_nan = bus.is_inf_nan_in;
            s1_d.sign_nan   = bus.sign_nan_in;
            s1_d.mant_nan   = bus.mant_nan_in;
            s1_d.rnd        = rnd_mode_e'(bus.rnd_in);
        end
    end

    mul_rnd_inc #(.MANT_W(MANT_W)) u_rnd_inc (
        .sig  (s1_q.sig),
        .g    (s1_q.g),
        .s    (s1_q.s),
        .sign (s1_q.sign),
        .rnd  (s1_q.rnd),
        .m    (m),
        .inc  (inc)
    );

    // A carry out of the mantissa can only come from an increment; it renormalizes to 1.0 x 2^(e+1).
    assign carry   = m[MANT_W] & inc;
    assign e_r     = s1_q.e + {{(EW-1){1'b0}}, carry};
    assign mant_r  = carry ? '0 : m[MANT_W-1:0];
    assign ovf_r   = ~e_r[EW-1] & (e_r >= E_MAX);
    assign uflow_r = e_r[EW-1] | (e_r == '0);

    // Stage 2: round, flush underflow/zero to signed zero, flag overflow, register pass-through fields.
    always_comb begin
        s2_valid_d   = s2_ready ? s1_valid_q : s2_valid_q;
        is_inf_nan_d = is_inf_nan_q;
        sign_nan_d   = sign_nan_q;
        mant_4_d     = mant_4_q;
        rnd_d        = rnd_q;
        sign_1_d     = sign_1_q;
        overflow_d   = overflow_q;
        expo_3_d     = expo_3_q;
        mant_3_d     = mant_3_q;
        inexact_d    = inexact_q;
        if (s2_load) begin
            expo_3_d   = e_r[EXPO_W-1:0];
            mant_3_d   = mant_r;
            overflow_d = ovf_r & ~s1_q.is_inf_nan;
            if (uflow_r | s1_q.is_zero) begin
                expo_3_d   = '0;
                mant_3_d   = '0;
                overflow_d = 1'b0;
            end
            inexact_d    = (s1_q.g | s1_q.s) & ~s1_q.is_zero & ~s1_q.is_inf_nan;
            is_inf_nan_d = s1_q.is_inf_nan;
            sign_nan_d   = s1_q.sign_nan;
            mant_4_d     = s1_q.mant_nan;
            rnd_d        = s1_q.rnd;
            sign_1_d     = s1_q.sign;
        end
    end

    // Pipeline state; reset drops any in-flight beats and clears all outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            s1_q         <= '0;
            is_inf_nan_q <= 1'b0;
            sign_nan_q   <= 1'b0;
            mant_4_q     <= '0;
            rnd_q        <= '0;
            sign_1_q     <= 1'b0;
            overflow_q   <= 1'b0;
            expo_3_q     <= '0;
            mant_3_q     <= '0;
            inexact_q    <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s2_valid_q   <= s2_valid_d;
            s1_q         <= s1_d;
            is_inf_nan_q <= is_inf_nan_d;
            sign_nan_q   <= sign_nan_d;
            mant_4_q     <= mant_4_d;
            rnd_q        <= rnd_d;
            sign_1_q     <= sign_1_d;
            overflow_q   <= overflow_d;
            expo_3_q     <= expo_3_d;
            mant_3_q     <= mant_3_d;
            inexact_q    <= inexact_d;
        end
    end

    assign bus.out_valid  = s2_valid_q;
    assign bus.is_inf_nan = is_inf_nan_q;
    assign bus.sign_nan   = sign_nan_q;
    assign bus.mant_4     = mant_4_q;
    assign bus.rnd        = rnd_q;
    assign bus.sign_1     = sign_1_q;
    assign bus.overflow   = overflow_q;
    assign bus.expo_3     = expo_3_q;
    assign bus.mant_3     = mant_3_q;
    assign bus.inexact    = inexact_q;

endmodule
